// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and default sizes for the two-cache memory arbiter.
package mem_arbiter_pkg;

    localparam int TIMEOUT_DEF = 15;
    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 32;

    typedef enum logic {
        INSTR_LOAD,
        INSTR_STORE
    } INSTR_TYPE;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_STORE,
        ARB_DONE,
        ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signals of the arbiter; master is the arbiter, slave its environment.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          r0_load_req, r0_store_req, r0_done;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_load_req, r1_store_req, r1_done;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wren, mem_load_req;
    logic          mem_load_completed, mem_store_completed;
    logic          err;

    modport master (
        input  r0_load_req, r0_store_req, r0_addr, r0_wdata,
        input  r1_load_req, r1_store_req, r1_addr, r1_wdata,
        input  mem_rdata, mem_load_completed, mem_store_completed,
        output r0_rdata, r0_done, r1_rdata, r1_done,
        output mem_address, mem_wdata, mem_wren, mem_load_req, err
    );

    modport slave (
        output r0_load_req, r0_store_req, r0_addr, r0_wdata,
        output r1_load_req, r1_store_req, r1_addr, r1_wdata,
        output mem_rdata, mem_load_completed, mem_store_completed,
        input  r0_rdata, r0_done, r1_rdata, r1_done,
        input  mem_address, mem_wdata, mem_wren, mem_load_req, err
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant; last holds the previously granted port.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt
);
    logic last;

    always_comb gnt = (req == 2'b11) ? ~last : req[1];

    // last starts at 1 so port 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (en && |req)
            last <= gnt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serves load/store block requests from two caches onto one RAM port,
// round-robin between caches, with a completion timeout that sets a sticky err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    localparam logic [2:0] IDLE    = ARB_IDLE;
    localparam logic [2:0] LOAD    = ARB_LOAD;
    localparam logic [2:0] STORE   = ARB_STORE;
    localparam logic [2:0] DONE    = ARB_DONE;
    localparam logic [2:0] RELEASE = ARB_RELEASE;
    localparam int         CW      = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    req;
    logic          sel, gnt, store_sel, cmpl;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    always_comb begin
        req       = {bus.r1_load_req | bus.r1_store_req, bus.r0_load_req | bus.r0_store_req};
        addr_sel  = gnt ? bus.r1_addr : bus.r0_addr;
        wdata_sel = gnt ? bus.r1_wdata : bus.r0_wdata;
        store_sel = gnt ? bus.r1_store_req : bus.r0_store_req;
        cmpl      = (state == LOAD) ? bus.mem_load_completed : bus.mem_store_completed;
    end

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (state == IDLE),
        .gnt   (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            sel              <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wren     <= 1'b0;
            bus.mem_load_req <= 1'b0;
            bus.r0_rdata     <= '0;
            bus.r1_rdata     <= '0;
            bus.r0_done      <= 1'b0;
            bus.r1_done      <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    // a dual load+store request is a writeback, so it goes out as a store
                    sel              <= gnt;
                    bus.mem_address  <= addr_sel;
                    bus.mem_wdata    <= wdata_sel;
                    bus.mem_wren     <= store_sel;
                    bus.mem_load_req <= ~store_sel;
                    cnt              <= '0;
                    state            <= store_sel ? STORE : LOAD;
                end
                LOAD, STORE: if (cmpl) begin
                    bus.mem_wren     <= 1'b0;
                    bus.mem_load_req <= 1'b0;
                    if (state == LOAD && !sel) bus.r0_rdata <= bus.mem_rdata;
                    if (state == LOAD && sel) bus.r1_rdata <= bus.mem_rdata;
                    bus.r0_done      <= ~sel;
                    bus.r1_done      <= sel;
                    state            <= DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    bus.mem_wren     <= 1'b0;
                    bus.mem_load_req <= 1'b0;
                    bus.err          <= 1'b1;
                    state            <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bus.r0_done <= 1'b0;
                    bus.r1_done <= 1'b0;
                    state       <= RELEASE;
                end
                RELEASE: if (!bus.mem_load_completed && !bus.mem_store_completed) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
